// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output req_valid, funct3, a, b, flush, resp_ready,
        input  req_ready, resp_valid, result, busy
    );

    modport slave (
        input  req_valid, funct3, a, b, flush, resp_ready,
        output req_ready, resp_valid, result, busy
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer sharing one WIDTH+1-bit adder.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// PREP  | record signs, take magnitudes, catch divide-by-zero / overflow
// CALC  | WIDTH shift-add or restoring-divide iterations
// FIXUP | apply result sign, select output half, register result
// DONE  | result presented until consumer takes it
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_sequencer_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIXUP, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         op;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   result_q;

    logic               is_div;
    logic               signed_a;
    logic               signed_b;
    logic               neg_a;
    logic               neg_b;
    logic               div_zero;
    logic               ovf;
    logic               special;
    logic [WIDTH-1:0]   special_res;
    logic               last;
    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_res;

    assign is_div   = op[2];
    assign signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign neg_a    = signed_a && opa[WIDTH-1];
    assign neg_b    = signed_b && opb[WIDTH-1];
    assign div_zero = is_div && (opb == '0);
    assign ovf      = is_div && !op[0] && (opa == {1'b1, {(WIDTH-1){1'b0}}}) && (opb == '1);
    assign special  = div_zero || ovf;
    assign last     = (cnt == CW'(WIDTH - 1));

    // Corner-case results; divide-by-zero wins since it cannot coincide with overflow
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op[1] ? opa : '1;
        else if (ovf)
            special_res = op[1] ? '0 : opa;
    end

    // Single adder: multiply adds the multiplicand, divide subtracts the divisor
    // from the remainder shifted left (its top bit included, hence WIDTH+1 bits)
    always_comb begin
        add_x = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
        add_y = '0;
        if (is_div)
            add_y = ~{1'b0, opb};
        else if (opa[0])
            add_y = {1'b0, opb};
        sum = add_x + add_y + {{WIDTH{1'b0}}, is_div};
    end

    // Sign correction and output selection for the FIXUP cycle
    always_comb begin
        prod = (sign_a ^ sign_b) ? -acc : acc;
        quo  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        case (op)
            3'b000:                 fix_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and state-decoded outputs; flush forces IDLE from anywhere
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.busy       = 1'b1;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid)
                    state_nxt = PREP;
            end
            PREP:  state_nxt = special ? DONE : CALC;
            CALC:  if (last) state_nxt = FIXUP;
            FIXUP: state_nxt = DONE;
            DONE: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush)
            state_nxt = IDLE;
    end

    // Operand, accumulator, counter and result datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            op       <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            result_q <= '0;
        end else if (!bus.flush) begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op  <= bus.funct3;
                        opa <= bus.a;
                        opb <= bus.b;
                    end
                end
                PREP: begin
                    opa    <= neg_a ? -opa : opa;
                    opb    <= neg_b ? -opb : opb;
                    acc    <= is_div ? {{WIDTH{1'b0}}, (neg_a ? -opa : opa)} : '0;
                    sign_a <= neg_a;
                    sign_b <= neg_b;
                    cnt    <= '0;
                    if (special)
                        result_q <= special_res;
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        if (sum[WIDTH])
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                        else
                            acc <= {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= {sum, acc[WIDTH-1:1]};
                        opa <= opa >> 1;
                    end
                end
                FIXUP: result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and reference-model checks of the multiply/divide sequencer.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();
    muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: one pop per response handshake
    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got %h expected no response", bus.result);
            end else begin
                check("result", bus.result, exp_q.pop_front());
            end
        end
    end

    function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic ovf;
        ovf = (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
        p = '0;
        case (f)
            3'b000: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; return p[W-1:0]; end
            3'b001: begin p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b}; return p[2*W-1:W]; end
            3'b010: begin p = {{W{a[W-1]}}, a} * {{W{1'b0}}, b}; return p[2*W-1:W]; end
            3'b011: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; return p[2*W-1:W]; end
            3'b100: return (b == 0) ? '1 : ovf ? a : W'($signed(a) / $signed(b));
            3'b101: return (b == 0) ? '1 : a / b;
            3'b110: return (b == 0) ? a : ovf ? '0 : W'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic idle_check(input string name);
        check(name, W'({bus.resp_valid, bus.req_ready, bus.busy}), W'(3'b010));
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                          input int stall);
        int n;
        logic busy_ok;
        logic hold_ok;
        logic [W-1:0] held;
        check({name, "_req_ready"}, W'(bus.req_ready), W'(1));
        exp_q.push_back(exp);
        bus.resp_ready = (stall == 0);
        bus.req_valid  = 1'b1;
        bus.funct3     = f;
        bus.a          = a;
        bus.b          = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        while (!bus.resp_valid && n < 100) begin
            busy_ok &= bus.busy;
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, W'(n), W'(lat));
        check({name, "_busy"}, W'(busy_ok & bus.busy), W'(1));
        if (stall > 0) begin
            held = bus.result;
            hold_ok = 1'b1;
            repeat (stall) begin
                @(posedge clk); #1;
                hold_ok &= bus.resp_valid & !bus.req_ready & bus.busy & (bus.result == held);
            end
            check({name, "_hold"}, W'(hold_ok), W'(1));
            bus.resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        idle_check({name, "_after_resp"});
    endtask

    task automatic start_unchecked(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_valid = 1'b1;
        bus.funct3    = 3'b000;
        bus.a         = a;
        bus.b         = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
    endtask

    task automatic quiet_check(input string name);
        logic seen;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= bus.resp_valid;
        end
        check(name, W'(seen), W'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] held;
        logic [2:0] f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int lat;

        bus.req_valid  = 1'b0;
        bus.funct3     = '0;
        bus.a          = '0;
        bus.b          = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        idle_check("reset_outputs");
        check("reset_result", bus.result, '0);
        rst = 1'b0;

        run_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, W + 2, 0);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, W + 2, 0);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, W + 2, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W + 2, 0);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, W + 2, 0);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, W + 2, 0);
        run_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        W + 2, 0);
        run_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         W + 2, 0);
        run_op("divu_z", 3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,     0);
        run_op("rem_z",  3'b110, 32'd5,         32'd0,         32'd5,         1,     0);
        run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,     0);
        run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,     0);
        run_op("bp",     3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, W + 2, 5);
        run_op("bp_next", 3'b000, 32'd6,        32'd9,         32'd54,        W + 2, 0);

        held = bus.result;
        start_unchecked(32'd11, 32'd13);
        check("flush_pre_busy", W'({bus.busy, bus.resp_valid}), W'(2'b10));
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        idle_check("flush_idle");
        check("flush_result_kept", bus.result, held);
        quiet_check("flush_no_resp");
        run_op("mul_after_flush", 3'b000, 32'd3, 32'd5, 32'd15, W + 2, 0);

        start_unchecked(32'd11, 32'd13);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_check("rst_idle");
        check("rst_result", bus.result, '0);
        quiet_check("rst_no_resp");
        run_op("mul_after_rst", 3'b000, 32'd3, 32'd5, 32'd15, W + 2, 0);

        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        idle_check("flush_blocks_req");
        @(posedge clk); #1;
        idle_check("flush_blocks_req_later");

        for (int i = 0; i < 300; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            lat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == '1))) ? 1 : W + 2;
            run_op("rand", f, a, b, ref_model(f, a, b), lat, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", W'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
